// File: rtl/nasti_stream_pkg.sv
// Shared types and helpers for the NASTI stream transmitter and receiver.
package nasti_stream_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_t;

  localparam int MAX_BYTES          = 128;
  localparam int DEFAULT_DATA_WIDTH = 64;

  function automatic int bytes_of(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int byte_shift(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  localparam int DEFAULT_BYTES      = bytes_of(DEFAULT_DATA_WIDTH);
  localparam int DEFAULT_BYTE_SHIFT = byte_shift(DEFAULT_DATA_WIDTH);

  // The shift overflows to zero for a full 128-byte beat, so the mask becomes all ones.
  function automatic logic [MAX_BYTES-1:0] keep_mask(input logic [7:0] len_lsbs);
    return (MAX_BYTES'(2) << len_lsbs) - MAX_BYTES'(1);
  endfunction

endpackage

// File: rtl/nasti_stream_channel.sv
// NASTI stream channel: one AXI-stream style beat per t_valid && t_ready.
interface nasti_stream_channel #(
  parameter int ID_WIDTH   = 1,
  parameter int DEST_WIDTH = 1,
  parameter int USER_WIDTH = 1,
  parameter int DATA_WIDTH = 64
);
  logic                    t_valid;
  logic                    t_ready;
  logic [DATA_WIDTH-1:0]   t_data;
  logic [DATA_WIDTH/8-1:0] t_keep;
  logic [DATA_WIDTH/8-1:0] t_strb;
  logic                    t_last;
  logic [ID_WIDTH-1:0]     t_id;
  logic [DEST_WIDTH-1:0]   t_dest;
  logic [USER_WIDTH-1:0]   t_user;

  modport master (
    output t_valid, t_data, t_keep, t_strb, t_last, t_id, t_dest, t_user,
    input  t_ready
  );

  modport slave (
    input  t_valid, t_data, t_keep, t_strb, t_last, t_id, t_dest, t_user,
    output t_ready
  );
endinterface

// File: rtl/nasti_stream_tx.sv
// Frames a byte-length command plus a word feed into a stream packet with t_last and a partial final keep.
// One-cycle registered output; wr_ready drops combinationally while the output beat is stalled.
module nasti_stream_tx
  import nasti_stream_pkg::*;
#(
  parameter int ID_WIDTH   = 1,
  parameter int DEST_WIDTH = 1,
  parameter int USER_WIDTH = 1,
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  input  logic [DEST_WIDTH-1:0] cmd_dest,
  input  logic [USER_WIDTH-1:0] cmd_user,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  nasti_stream_channel.master   dest
);

  localparam int BYTES = bytes_of(DATA_WIDTH);
  localparam int SHIFT = byte_shift(DATA_WIDTH);

  tx_state_t             state_q, state_d;
  logic [LEN_WIDTH-1:0]  beats_left_q, beats_left_d;
  logic [BYTES-1:0]      last_keep_q, last_keep_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [DEST_WIDTH-1:0] dst_q, dst_d;
  logic [USER_WIDTH-1:0] user_q, user_d;

  logic                  t_valid_q, t_valid_d;
  logic [DATA_WIDTH-1:0] t_data_q, t_data_d;
  logic [BYTES-1:0]      t_keep_q, t_keep_d;
  logic                  t_last_q, t_last_d;
  logic [ID_WIDTH-1:0]   t_id_q, t_id_d;
  logic [DEST_WIDTH-1:0] t_dest_q, t_dest_d;
  logic [USER_WIDTH-1:0] t_user_q, t_user_d;

  logic       cmd_fire;
  logic       data_fire;
  logic       last_beat;
  logic [7:0] len_lsbs;

  assign cmd_ready = (state_q == IDLE);
  assign wr_ready  = (state_q == SEND) && (!t_valid_q || dest.t_ready);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign data_fire = wr_valid && wr_ready;
  assign last_beat = (beats_left_q == '0);
  assign len_lsbs  = 8'(cmd_len % LEN_WIDTH'(BYTES));

  always_comb begin
    state_d      = state_q;
    beats_left_d = beats_left_q;
    last_keep_d  = last_keep_q;
    id_d         = id_q;
    dst_d        = dst_q;
    user_d       = user_q;
    t_valid_d    = t_valid_q;
    t_data_d     = t_data_q;
    t_keep_d     = t_keep_q;
    t_last_d     = t_last_q;
    t_id_d       = t_id_q;
    t_dest_d     = t_dest_q;
    t_user_d     = t_user_q;

    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          state_d      = SEND;
          beats_left_d = cmd_len >> SHIFT;
          last_keep_d  = BYTES'(keep_mask(len_lsbs));
          id_d         = cmd_id;
          dst_d        = cmd_dest;
          user_d       = cmd_user;
        end
      end
      SEND: begin
        if (data_fire) begin
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            beats_left_d = beats_left_q - LEN_WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A load in the same cycle as a drain simply replaces the outgoing beat.
    if (data_fire) begin
      t_valid_d = 1'b1;
      t_data_d  = wr_data;
      t_keep_d  = last_beat ? last_keep_q : '1;
      t_last_d  = last_beat;
      t_id_d    = id_q;
      t_dest_d  = dst_q;
      t_user_d  = user_q;
    end else if (t_valid_q && dest.t_ready) begin
      t_valid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      beats_left_q <= '0;
      last_keep_q  <= '0;
      id_q         <= '0;
      dst_q        <= '0;
      user_q       <= '0;
      t_valid_q    <= 1'b0;
      t_data_q     <= '0;
      t_keep_q     <= '0;
      t_last_q     <= 1'b0;
      t_id_q       <= '0;
      t_dest_q     <= '0;
      t_user_q     <= '0;
    end else begin
      state_q      <= state_d;
      beats_left_q <= beats_left_d;
      last_keep_q  <= last_keep_d;
      id_q         <= id_d;
      dst_q        <= dst_d;
      user_q       <= user_d;
      t_valid_q    <= t_valid_d;
      t_data_q     <= t_data_d;
      t_keep_q     <= t_keep_d;
      t_last_q     <= t_last_d;
      t_id_q       <= t_id_d;
      t_dest_q     <= t_dest_d;
      t_user_q     <= t_user_d;
    end
  end

  assign dest.t_valid = t_valid_q;
  assign dest.t_data  = t_data_q;
  assign dest.t_keep  = t_keep_q;
  assign dest.t_strb  = t_keep_q;
  assign dest.t_last  = t_last_q;
  assign dest.t_id    = t_id_q;
  assign dest.t_dest  = t_dest_q;
  assign dest.t_user  = t_user_q;

endmodule

// File: tb/tb_nasti_stream_tx.sv
// Scoreboard bench for nasti_stream_tx: accepted words queue expected beats, the stream monitor pops them.
module tb_nasti_stream_tx;

  localparam int IW = 4;
  localparam int DW = 2;
  localparam int UW = 3;
  localparam int DATA_W = 64;
  localparam int LW = 16;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [LW-1:0] cmd_len = '0;
  logic [IW-1:0] cmd_id = '0;
  logic [DW-1:0] cmd_dest = '0;
  logic [UW-1:0] cmd_user = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [63:0]   wr_data = '0;
  logic          rdy = 1'b0;

  always #5 aclk = ~aclk;

  nasti_stream_channel #(.ID_WIDTH(IW), .DEST_WIDTH(DW), .USER_WIDTH(UW), .DATA_WIDTH(DATA_W)) ch ();

  assign ch.t_ready = rdy;

  nasti_stream_tx #(
    .ID_WIDTH(IW), .DEST_WIDTH(DW), .USER_WIDTH(UW), .DATA_WIDTH(DATA_W), .LEN_WIDTH(LW)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .cmd_id(cmd_id), .cmd_dest(cmd_dest), .cmd_user(cmd_user),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .dest(ch)
  );

  typedef struct packed {
    logic [63:0]   data;
    logic [7:0]    keep;
    logic          last;
    logic [IW-1:0] id;
    logic [DW-1:0] dst;
    logic [UW-1:0] user;
  } beat_t;

  beat_t exp_q[$];
  int    out_cyc[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    ready_mode = 0;
  int    rphase = 0;
  bit    rand_valid = 1'b0;
  bit    stall_prev = 1'b0;
  logic [89:0] stall_fields;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge aclk) cyc++;

  // Mode 0: always ready; mode 1: repeating 1,0,0 pattern.
  always @(posedge aclk) begin
    #1;
    if (ready_mode == 0) begin
      rdy = 1'b1;
    end else begin
      rdy = (rphase == 0);
      rphase = (rphase + 1) % 3;
    end
  end

  always @(negedge aclk) begin
    if (aresetn) begin
      logic [89:0] cur;
      cur = {ch.t_data, ch.t_keep, ch.t_strb, ch.t_last, ch.t_id, ch.t_dest, ch.t_user};
      if (stall_prev) begin
        chk("stall_valid_hold", 128'(ch.t_valid), 1);
        chk("stall_fields_hold", 128'(cur), 128'(stall_fields));
      end
      if (ch.t_valid && !ch.t_ready) begin
        chk("wr_ready_while_stalled", 128'(wr_ready), 0);
        stall_prev   = 1'b1;
        stall_fields = cur;
      end else begin
        stall_prev = 1'b0;
      end
      if (ch.t_valid && ch.t_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 128'(exp_q.size()), 1);
        end else begin
          beat_t e;
          beat_t g;
          e = exp_q.pop_front();
          g = '{data: ch.t_data, keep: ch.t_keep, last: ch.t_last,
                id: ch.t_id, dst: ch.t_dest, user: ch.t_user};
          chk("beat", 128'(g), 128'(e));
          chk("strb_eq_keep", 128'(ch.t_strb), 128'(e.keep));
          out_cyc.push_back(cyc);
        end
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after the final accepted word.
  task automatic send_pkt(input logic [15:0] len, input logic [IW-1:0] id, input logic [DW-1:0] dd,
                          input logic [UW-1:0] uu, input int n_push, input int n_feed);
    int    nbeats;
    int    i;
    int    guard;
    logic [7:0] lastk;
    beat_t e;
    nbeats = int'(len) / 8 + 1;
    lastk  = 8'hFF >> (7 - int'(len) % 8);
    cmd_valid = 1'b1;
    cmd_len   = len;
    cmd_id    = id;
    cmd_dest  = dd;
    cmd_user  = uu;
    guard = 0;
    forever begin
      @(negedge aclk);
      if (cmd_ready) break;
      guard++;
      if (guard > 50) begin
        chk("cmd_ready_timeout", 128'(cmd_ready), 1);
        break;
      end
      @(posedge aclk); #1;
    end
    @(posedge aclk); #1;
    cmd_valid = 1'b0;
    i = 0;
    guard = 0;
    while (i < n_feed) begin
      wr_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      wr_data  = {$urandom, $urandom};
      @(negedge aclk);
      chk("cmd_ready_in_send", 128'(cmd_ready), 0);
      if (wr_valid && wr_ready) begin
        if (i < n_push) begin
          e.data = wr_data;
          e.last = (i == nbeats - 1);
          e.keep = (i == nbeats - 1) ? lastk : 8'hFF;
          e.id   = id;
          e.dst  = dd;
          e.user = uu;
          exp_q.push_back(e);
        end
        i++;
      end
      guard++;
      @(posedge aclk); #1;
      if (guard > nbeats * 4 + 50) begin
        chk("wr_ready_timeout", 128'(i), 128'(n_feed));
        break;
      end
    end
    wr_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(posedge aclk);
      guard++;
    end
    #1;
    chk("drain_empty", 128'(exp_q.size()), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_t_valid"}, 128'(ch.t_valid), 0);
    chk({tag, "_t_data"}, 128'(ch.t_data), 0);
    chk({tag, "_t_keep_strb"}, 128'({ch.t_keep, ch.t_strb}), 0);
    chk({tag, "_t_last"}, 128'(ch.t_last), 0);
    chk({tag, "_t_id_dest_user"}, 128'({ch.t_id, ch.t_dest, ch.t_user}), 0);
    chk({tag, "_cmd_ready"}, 128'(cmd_ready), 1);
    chk({tag, "_wr_ready"}, 128'(wr_ready), 0);
  endtask

  initial begin
    repeat (3) @(posedge aclk);
    #1;
    chk_reset_outputs("reset");
    #1 aresetn = 1'b1;
    @(posedge aclk); #1;

    // 20 bytes over 64-bit words: 3 beats, 4-byte tail.
    out_cyc.delete();
    send_pkt(16'd19, 4'h5, 2'h2, 3'h6, 3, 3);
    drain();
    chk("t1_beat_count", 128'(out_cyc.size()), 3);

    // Two single-beat packets back to back: exactly one idle cycle between them.
    out_cyc.delete();
    send_pkt(16'd7, 4'hA, 2'h1, 3'h3, 1, 1);
    send_pkt(16'd0, 4'h3, 2'h3, 3'h1, 1, 1);
    drain();
    chk("t2_beat_count", 128'(out_cyc.size()), 2);
    if (out_cyc.size() == 2) chk("t2_gap", 128'(out_cyc[1] - out_cyc[0]), 2);

    // Stalled downstream with a bursty word feed.
    out_cyc.delete();
    ready_mode = 1;
    rand_valid = 1'b1;
    send_pkt(16'd63, 4'h9, 2'h0, 3'h5, 8, 8);
    drain();
    chk("t3_beat_count", 128'(out_cyc.size()), 8);
    ready_mode = 0;
    rand_valid = 1'b0;
    @(posedge aclk); #1;

    // Maximum length: 8192 full beats.
    out_cyc.delete();
    send_pkt(16'hFFFF, 4'hC, 2'h2, 3'h7, 8192, 8192);
    drain();
    chk("t4_beat_count", 128'(out_cyc.size()), 8192);

    // Reset while beat 3 of a 4-beat packet sits in the output register.
    out_cyc.delete();
    send_pkt(16'd31, 4'h6, 2'h1, 3'h2, 2, 3);
    #1;
    chk("t5_valid_before_reset", 128'(ch.t_valid), 1);
    chk("t5_queue_before_reset", 128'(exp_q.size()), 0);
    aresetn = 1'b0;
    #1;
    chk_reset_outputs("t5_async");
    repeat (2) @(posedge aclk);
    #2 aresetn = 1'b1;
    @(posedge aclk); #1;
    chk("t5_cmd_ready_after", 128'(cmd_ready), 1);
    out_cyc.delete();
    send_pkt(16'd15, 4'h2, 2'h3, 3'h4, 2, 2);
    drain();
    repeat (5) @(posedge aclk);
    #1;
    chk("t5_beat_count", 128'(out_cyc.size()), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
